// File: rtl/nibble_serial_add_sched_if.sv
// rtl/nibble_serial_add_sched_if.sv - request, operand and result bundle for the nibble-serial add scheduler
interface nibble_serial_add_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         cin0;
  logic         cin1;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  gnt0, gnt1, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output gnt0, gnt1, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/nibble_serial_add_sched.sv
// rtl/nibble_serial_add_sched.sv - round-robin scheduler driving one 4-bit carry-select slice nibble-serially
module nibble_serial_add_sched #(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_add_sched_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  nib_mask;
  logic          carry;
  logic          last;
  logic          id;
  logic [KW-1:0] k;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [4:0]    sum_c0;
  logic [4:0]    sum_c1;
  logic [4:0]    slice;
  logic          pick1;

  // Shift-based nibble select keeps the slice index width-agnostic.
  always_comb begin
    nib_a    = 4'(opa >> {k, 2'b00});
    nib_b    = 4'(opb >> {k, 2'b00});
    sum_c0   = {1'b0, nib_a} + {1'b0, nib_b};
    sum_c1   = {1'b0, nib_a} + {1'b0, nib_b} + 5'd1;
    slice    = carry ? sum_c1 : sum_c0;
    nib_mask = W'(4'hF) << {k, 2'b00};
    acc_next = (acc & ~nib_mask) | (W'(slice[3:0]) << {k, 2'b00});
  end

  // last==0 means client 0 was served most recently, so client 1 wins a tie.
  assign pick1 = bus.req1 & (~bus.req0 | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      k           <= '0;
      last        <= 1'b1;
      id          <= 1'b0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= 1'b0;
      bus.sum     <= '0;
      bus.cout    <= 1'b0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            opa      <= pick1 ? bus.a1 : bus.a0;
            opb      <= pick1 ? bus.b1 : bus.b0;
            carry    <= pick1 ? bus.cin1 : bus.cin0;
            k        <= '0;
            id       <= pick1;
            last     <= pick1;
            bus.gnt0 <= ~pick1;
            bus.gnt1 <= pick1;
            bus.busy <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          acc   <= acc_next;
          carry <= slice[4];
          k     <= k + KW'(1);
          if (k == K_LAST) begin
            bus.sum     <= acc_next;
            bus.cout    <= slice[4];
            bus.done_id <= id;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_add_sched.md
# nibble_serial_add_sched

Two-requester scheduler that shares one 4-bit carry-select adder slice to perform full 16-bit additions nibble-serially. It arbitrates between two clients round-robin, latches the winner's operands, and steps the slice across the nibbles, least significant first, with a registered inter-nibble carry. It returns a registered sum, carry-out and requester ID. It sits between operand producers and the shared CSA slice, trading the area of a full-width adder for multi-cycle latency.

## Interface
- `NIBBLES`, default 4: nibble count; operand width is `W = 4*NIBBLES`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0`, `req1`  in  1  add request from client 0 / client 1.
- `a0`, `b0`, `a1`, `b1`  in  W  operands; each must be stable while its `req` is high.
- `cin0`, `cin1`  in  1  carry-in per client.
- `gnt0`, `gnt1`  out  1  one-cycle pulse: operands have been captured.
- `busy`  out  1  high in the ADD and DONE states.
- `done`  out  1  one-cycle pulse: `sum`, `cout` and `done_id` are valid.
- `done_id`  out  1  client the result belongs to.
- `sum`  out  W  result register.
- `cout`  out  1  final carry-out.

## Operation
- State machine: IDLE, ADD, DONE.
- **IDLE:**
  - If any `req` is high at an edge, the block:
    - picks the winner;
    - latches its A, B and cin into `opa`, `opb` and `carry`;
    - sets `k=0`, pulses the matching `gnt`, records `id`;
    - moves to ADD.
  - If no `req` is high, it stays in IDLE.
- **Arbitration:**
  - One request: that requester wins.
  - Both requesting: the requester not granted last wins.
  - The `last` pointer resets to 1, so client 0 wins the first tie.
  - `last` updates only on a grant.
- **ADD:**
  - Each edge processes nibble `k` of `opa`/`opb`.
  - The slice forms both `nib_a + nib_b + 0` and `nib_a + nib_b + 1` (5 bits each) and selects between them by `carry`.
  - The low 4 bits are written to `acc[4k+3:4k]`; bit 4 goes to `carry`; `k` increments.
  - On the edge that processes `k=NIBBLES-1`:
    - `sum <= ` completed accumulator (including the final nibble).
    - `cout <= ` final carry, `done_id <= id`, `done <= 1`.
    - State moves to DONE.
- **DONE:**
  - Lasts one cycle, then returns to IDLE.
  - Requests are not accepted in DONE.
- **Output holding:**
  - `sum`, `cout` and `done_id` change only at completion.
  - They hold between completions; partial nibbles are never visible on `sum`.
- **Arithmetic:** modulo 2^W; `cout` is bit W of `A+B+cin`.
- **Request withdrawal:** a `req` dropped before it is granted is simply not served. No state is kept for it.
- **Requests while busy:** these are held off (no `gnt`) and are evaluated at the next IDLE edge.
- **Asynchronous reset (any state, including mid-ADD):**
  - State returns to IDLE; `k`, `carry`, `acc`, `opa`, `opb` clear; `last` returns to 1.
  - The in-flight operation is discarded and produces no `done`.

## Timing
- Reset values:
  - `gnt0=gnt1=busy=done=done_id=cout=0`.
  - `sum=0`.
- For an operation granted at edge E0 (requester seen in IDLE):
  - `gnt` is high in cycle E0–E1 and `busy` rises after E0.
  - Nibbles are processed at edges E1..E4 (for `NIBBLES=4`).
  - `done` is high in cycle E4–E5, with results valid from E4 onward.
  - At E5 the block returns to IDLE and `busy` falls.
  - The next grant is possible at E6 at the earliest.
- Latency from grant to `done` is `NIBBLES` cycles. Minimum issue interval is `NIBBLES+2` cycles.
- `done` and `gnt` are registered single-cycle pulses, and never both high in the same cycle.
- Operand inputs are sampled only at the grant edge; later changes have no effect on the operation.

## Test plan
- **Single add:** `req0` with A=0x1234, B=0x0FFF, cin=0.
  - `gnt0` pulses one cycle after the edge.
  - 4 cycles later, `done=1`, `sum=0x2233`, `cout=0`, `done_id=0`.
- **Full carry ripple:** A=0xFFFF, B=0x0001, cin=0 → `sum=0x0000`, `cout=1`. Also A=0x7FFF, B=0x0000, cin=1 → `sum=0x8000`, `cout=0`.
- **Simultaneous requests after reset:** `req0`/`req1` both high, client 0 = 1+2, client 1 = 0xFFFF+0xFFFF cin=1.
  - `gnt0` first, then `done_id=0` with `sum=0x0003`.
  - Then `gnt1` at E6, and `done_id=1` with `sum=0xFFFF`, `cout=1`.
  - A third tie grants client 0 again.
- **Request held off while busy:** `req1` asserted during ADD of a client-0 op → no `gnt1` until the IDLE edge. Operands changed after `gnt1` do not alter the result.
- **Reset mid-op:** `rst_n` low during the second ADD cycle.
  - All outputs return to 0 immediately and no `done` follows.
  - After release, a new op 0x00FF+0x0001 yields `sum=0x0100`.
- **Withdrawn request:** `req1` pulsed only while busy, dropped before IDLE → no `gnt1` and no `done`; the block stays in IDLE with `busy=0`.
